// File: rtl/icap_readback_pkg.sv
// icap_readback_pkg: constants shared by the ICAP readback block and the
// multiboot reboot sequencer.
//   - ICAP command words (dummy, sync, NOP, CMD-write header, DESYNC code)
//   - read headers for STAT / WBSTAR / BOOTSTS / IDCODE, indexed by sel
//   - ZX-Uno register addresses
//   - readback FSM state encoding
package icap_readback_pkg;

    localparam logic [31:0] ICAP_DUMMY      = 32'hFFFF_FFFF;
    localparam logic [31:0] ICAP_SYNC       = 32'hAA99_5566;
    localparam logic [31:0] ICAP_NOP        = 32'h2000_0000;
    localparam logic [31:0] ICAP_CMD_WR     = 32'h3000_8001;
    localparam logic [31:0] ICAP_CMD_DESYNC = 32'h0000_000D;

    localparam logic [31:0] HDR_STAT    = 32'h2800_E001;
    localparam logic [31:0] HDR_WBSTAR  = 32'h2802_0001;
    localparam logic [31:0] HDR_BOOTSTS = 32'h2802_C001;
    localparam logic [31:0] HDR_IDCODE  = 32'h2801_8001;

    localparam logic [7:0] ZXUNO_ADDR_ICAPCTRL = 8'hFE;
    localparam logic [7:0] ZXUNO_ADDR_ICAPDATA = 8'hFF;

    // Words emitted in the sync and desync phases.
    localparam logic [3:0] PRE_LAST  = 4'd5;
    localparam logic [3:0] POST_LAST = 4'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_PRE,
        ST_SWRD,
        ST_RDWAIT,
        ST_SWWR,
        ST_POST,
        ST_DONE
    } state_t;

    function automatic logic [31:0] rd_header(input logic [1:0] sel);
        logic [31:0] hdr;
        case (sel)
            2'd0:    hdr = HDR_STAT;
            2'd1:    hdr = HDR_WBSTAR;
            2'd2:    hdr = HDR_BOOTSTS;
            default: hdr = HDR_IDCODE;
        endcase
        return hdr;
    endfunction

endpackage

// File: rtl/icap_readback_cmd_rom.sv
// icap_cmd_rom: combinational map from (state, word index, sel) to the ICAP
// bus values {ce, we, wdata} that the readback FSM drives in that cycle.
// Ports:
//   i_state  FSM state the word belongs to
//   i_idx    word index within PRE / POST
//   i_sel    selected configuration register (picks the read header)
//   o_ce     active-high chip select
//   o_we     1 = write, 0 = read
//   o_wdata  logical (unswapped) command word
module icap_cmd_rom
    import icap_readback_pkg::*;
(
    input  state_t      i_state,
    input  logic [3:0]  i_idx,
    input  logic [1:0]  i_sel,
    output logic        o_ce,
    output logic        o_we,
    output logic [31:0] o_wdata
);

    always_comb begin
        o_ce    = 1'b0;
        o_we    = 1'b1;
        o_wdata = ICAP_NOP;
        case (i_state)
            ST_IDLE, ST_REQ: begin
                o_wdata = ICAP_DUMMY;
            end
            ST_PRE: begin
                // First word is a dummy with the port deselected.
                o_ce = (i_idx != 4'd0);
                case (i_idx)
                    4'd0:    o_wdata = ICAP_DUMMY;
                    4'd1:    o_wdata = ICAP_SYNC;
                    4'd3:    o_wdata = rd_header(i_sel);
                    default: o_wdata = ICAP_NOP;
                endcase
            end
            ST_SWRD: begin
                o_we = 1'b0;
            end
            ST_RDWAIT: begin
                o_ce = 1'b1;
                o_we = 1'b0;
            end
            ST_POST: begin
                o_ce = 1'b1;
                case (i_idx)
                    4'd0:    o_wdata = ICAP_CMD_WR;
                    4'd1:    o_wdata = ICAP_CMD_DESYNC;
                    default: o_wdata = ICAP_NOP;
                endcase
            end
            default: begin
                // SWWR and DONE: deselected, write direction, NOP.
            end
        endcase
    end

endmodule

// File: rtl/icap_readback.sv
// icap_readback: reads one Artix-7 configuration register (STAT, WBSTAR,
// BOOTSTS, IDCODE) through the ICAPE2 port and exposes it via two ZX-Uno
// registers.
//   ADDR_ICAPCTRL (W) din[1:0] = sel, starts a readback when idle
//                 (R) {busy, valid, 4'b0, sel}
//   ADDR_ICAPDATA (R) captured word, MSB byte first, wrapping
// Ports:
//   clk, rst                  clock (also ICAP clock), sync active-high reset
//   zxuno_addr, regaddr_changed, zxuno_regrd, zxuno_regwr, din   CPU side
//   dout, oe                  combinational read data / valid
//   icap_req, icap_gnt        arbiter handshake
//   icap_ce, icap_we, icap_wdata, icap_rdata   logical ICAP bus (registered)
// Build option: ICAP_AUTOREAD_EN makes the block read BOOTSTS right after
// reset without CPU action.
module icap_readback
    import icap_readback_pkg::*;
#(
    parameter logic [7:0] ADDR_ICAPCTRL = ZXUNO_ADDR_ICAPCTRL,
    parameter logic [7:0] ADDR_ICAPDATA = ZXUNO_ADDR_ICAPDATA,
    parameter int         READ_LAT      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  zxuno_addr,
    input  logic        regaddr_changed,
    input  logic        zxuno_regrd,
    input  logic        zxuno_regwr,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        oe,
    output logic        icap_req,
    input  logic        icap_gnt,
    output logic        icap_ce,
    output logic        icap_we,
    output logic [31:0] icap_wdata,
    input  logic [31:0] icap_rdata
);

    localparam logic [3:0] LAT_LAST = 4'(READ_LAT - 1);

`ifdef ICAP_AUTOREAD_EN
    localparam state_t     RST_STATE = ST_REQ;
    localparam logic [1:0] RST_SEL   = 2'd2;
    localparam logic       RST_REQ   = 1'b1;
`else
    localparam state_t     RST_STATE = ST_IDLE;
    localparam logic [1:0] RST_SEL   = 2'd0;
    localparam logic       RST_REQ   = 1'b0;
`endif

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [1:0]  r_sel;
    logic        r_valid;
    logic [31:0] r_data;
    logic [1:0]  r_bcnt;     // next byte to be read
    logic [1:0]  r_bcur;     // byte shown for the rest of the current strobe
    logic        r_regwr_d;
    logic        r_regrd_d;
    logic        r_req;
    logic        r_ce;
    logic        r_we;
    logic [31:0] r_wdata;

    state_t      w_state_next;
    logic [3:0]  w_cnt_next;
    logic [1:0]  w_sel_next;
    logic        w_start;
    logic        w_capture;
    logic        w_wr_edge;
    logic        w_rd_edge;
    logic        w_busy;
    logic        w_rom_ce;
    logic        w_rom_we;
    logic [31:0] w_rom_wdata;
    logic [1:0]  w_bsel;
    logic        w_unused;

    assign w_wr_edge = zxuno_regwr & ~r_regwr_d;
    assign w_rd_edge = zxuno_regrd & ~r_regrd_d;
    assign w_busy    = (r_state != ST_IDLE);
    assign w_unused  = ^din[7:2];

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_sel_next   = r_sel;
        w_start      = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_wr_edge && zxuno_addr == ADDR_ICAPCTRL) begin
                    w_state_next = ST_REQ;
                    w_sel_next   = din[1:0];
                    w_start      = 1'b1;
                end
            end
            ST_REQ: begin
                if (icap_gnt) begin
                    w_state_next = ST_PRE;
                    w_cnt_next   = 4'd0;
                end
            end
            ST_PRE: begin
                if (r_cnt == PRE_LAST) begin
                    w_state_next = ST_SWRD;
                    w_cnt_next   = 4'd0;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            ST_SWRD: begin
                w_state_next = ST_RDWAIT;
                w_cnt_next   = 4'd0;
            end
            ST_RDWAIT: begin
                if (r_cnt == LAT_LAST) begin
                    w_state_next = ST_SWWR;
                    w_cnt_next   = 4'd0;
                    w_capture    = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            ST_SWWR: begin
                w_state_next = ST_POST;
                w_cnt_next   = 4'd0;
            end
            ST_POST: begin
                if (r_cnt == POST_LAST) begin
                    w_state_next = ST_DONE;
                    w_cnt_next   = 4'd0;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // The ROM is driven with next-state values so the bus outputs can be
    // registered and still line up with the state they belong to.
    icap_cmd_rom u_cmd_rom (
        .i_state (w_state_next),
        .i_idx   (w_cnt_next),
        .i_sel   (w_sel_next),
        .o_ce    (w_rom_ce),
        .o_we    (w_rom_we),
        .o_wdata (w_rom_wdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RST_STATE;
            r_cnt     <= 4'd0;
            r_sel     <= RST_SEL;
            r_valid   <= 1'b0;
            r_data    <= 32'd0;
            r_bcnt    <= 2'd0;
            r_bcur    <= 2'd0;
            r_regwr_d <= 1'b0;
            r_regrd_d <= 1'b0;
            r_req     <= RST_REQ;
            r_ce      <= 1'b0;
            r_we      <= 1'b1;
            r_wdata   <= ICAP_DUMMY;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_sel     <= w_sel_next;
            r_regwr_d <= zxuno_regwr;
            r_regrd_d <= zxuno_regrd;
            r_req     <= (w_state_next != ST_IDLE) && (w_state_next != ST_DONE);
            r_ce      <= w_rom_ce;
            r_we      <= w_rom_we;
            r_wdata   <= w_rom_wdata;

            if (w_start) begin
                r_valid <= 1'b0;
            end
            if (w_capture) begin
                r_data  <= icap_rdata;
                r_valid <= 1'b1;
            end

            if (w_capture || (regaddr_changed && zxuno_addr == ADDR_ICAPDATA)) begin
                r_bcnt <= 2'd0;
            end else if (w_rd_edge && zxuno_addr == ADDR_ICAPDATA) begin
                r_bcur <= r_bcnt;
                r_bcnt <= r_bcnt + 2'd1;
            end
        end
    end

    assign icap_req   = r_req;
    assign icap_ce    = r_ce;
    assign icap_we    = r_we;
    assign icap_wdata = r_wdata;

    // On the first cycle of a strobe the counter has not advanced yet; for
    // the rest of the strobe it already points past the byte being read.
    assign w_bsel = w_rd_edge ? r_bcnt : r_bcur;

    always_comb begin
        oe   = 1'b0;
        dout = 8'hFF;
        if (zxuno_regrd) begin
            if (zxuno_addr == ADDR_ICAPCTRL) begin
                oe   = 1'b1;
                dout = {w_busy, r_valid, 4'b0000, r_sel};
            end else if (zxuno_addr == ADDR_ICAPDATA) begin
                oe = 1'b1;
                case (w_bsel)
                    2'd0: dout = r_data[31:24];
                    2'd1: dout = r_data[23:16];
                    2'd2: dout = r_data[15:8];
                    default: dout = r_data[7:0];
                endcase
            end
        end
    end

endmodule
